// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU/MDU encodings and multiply/divide FSM states
package alu_pkg;

  // ALUctr encodings, shared with the pipeline decoder
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  // md_op encodings
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_RUN  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_fix;

  // Multiply: acc_hi holds the partial product, acc_lo the multiplier shifting out.
  assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
  // Divide: acc_hi holds the partial remainder, acc_lo the dividend shifting
  // out on top while quotient bits shift in at the bottom.
  assign rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, m_q};
  // When rem_ge holds the true difference is below the divisor, so W bits suffice.
  assign rem_sub   = rem_shift[WIDTH-1:0] - m_q;

  assign a_neg     = md_is_signed(op_q) & opa_q[WIDTH-1];
  assign b_neg     = md_is_signed(op_q) & opb_q[WIDTH-1];
  assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  // Next-state logic for the IDLE -> PREP -> RUN -> FIX sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    m_d      = m_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          opa_d   = a_i;
          opb_d   = b_i;
          state_d = MD_PREP;
        end
      end
      MD_PREP: begin
        m_d      = b_neg ? -opb_q : opb_q;
        acc_lo_d = a_neg ? -opa_q : opa_q;
        acc_hi_d = '0;
        neg_d    = a_neg ^ b_neg;
        rneg_d   = a_neg;
        div0_d   = (opb_q == '0);
        cnt_d    = '0;
        state_d  = MD_RUN;
      end
      MD_RUN: begin
        if (md_is_div(op_q)) begin
          acc_hi_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_hi_d = add_sum[WIDTH:1];
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + (SHW+1)'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (md_is_div(op_q)) begin
          if (div0_q) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            lo_d = '1;
            hi_d = opa_q;
          end else begin
            lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
            hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      m_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      m_q      <= m_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - combinational ALU plus iterative multiply/divide unit
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ALUctr,
  input  logic [WIDTH-1:0] src_1,
  input  logic [WIDTH-1:0] src_2,
  output logic [WIDTH-1:0] result,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [SHW-1:0] shamt;
  assign shamt = src_1[SHW-1:0];

  // Purely combinational ALU; undefined codes yield zero
  always_comb begin
    result = '0;
    case (ALUctr)
      ALU_ADD:  result = src_1 + src_2;
      ALU_SUB:  result = src_1 - src_2;
      ALU_AND:  result = src_1 & src_2;
      ALU_OR:   result = src_1 | src_2;
      ALU_SLT:  result[0] = $signed(src_1) < $signed(src_2);
      ALU_SLTU: result[0] = src_1 < src_2;
      ALU_LUI:  result[31:16] = src_2[15:0];
      ALU_SLL:  result = src_2 << shamt;
      ALU_SRL:  result = src_2 >> shamt;
      ALU_SRA:  result = $signed(src_2) >>> shamt;
      ALU_NOR:  result = ~(src_1 | src_2);
      ALU_XOR:  result = src_1 ^ src_2;
      default:  result = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mdu_iter (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (src_1),
    .b_i     (src_2),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized scoreboard bench for alu_mdu
module tb_alu_mdu;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ALUctr;
  logic [W-1:0] src_1, src_2, result, hi, lo;
  logic         md_start, busy, done;
  logic [1:0]   md_op;

  logic         rst64, start64, busy64, done64;
  logic [3:0]   alu64;
  logic [1:0]   op64;
  logic [63:0]  a64, b64, res64, hi64, lo64;

  int  checks = 0, failures = 0;
  int  cyc = 0, free_edge = 0, busy_from = 1, busy_to = 0;
  bit  mon_en = 1'b0;
  bit  exp_done;
  logic [W-1:0] mhi = '0, mlo = '0;
  logic [63:0]  ref_r;

  typedef struct {
    int           due;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ALUctr(ALUctr), .src_1(src_1), .src_2(src_2), .result(result),
    .md_start(md_start), .md_op(md_op), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst64), .ALUctr(alu64), .src_1(a64), .src_2(b64), .result(res64),
    .md_start(start64), .md_op(op64), .busy(busy64), .done(done64), .hi(hi64), .lo(lo64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int sb_s;
    sb_s = b;
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: return (a < b) ? 1 : 0;
      4'b0100: return {b[15:0], 16'h0000};
      4'b1000: return b << a[4:0];
      4'b1001: return b >> a[4:0];
      4'b1010: return sb_s >>> a[4:0];
      4'b1100: return ~(a | b);
      4'b1101: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] mdu_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, q, r;
    longint la, lb, p;
    ia = a; ib = b; la = ia; lb = ib;
    case (op)
      2'b00: begin p = la * lb; return p; end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib; r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Reference acceptance model: reset wins, starts only land when idle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      mhi = '0; mlo = '0;
      free_edge = cyc + 1;
      busy_from = 1; busy_to = 0;
    end else if (md_start && cyc >= free_edge) begin
      ref_r = mdu_ref(md_op, src_1, src_2);
      sb.push_back('{due: cyc + LAT, hi: ref_r[63:32], lo: ref_r[31:0]});
      busy_from = cyc; busy_to = cyc + LAT - 1;
      free_edge = cyc + LAT + 1;
    end
  end

  // Monitor: pops on each done pulse and checks hold/busy every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      exp_done = (sb.size() != 0) && (sb[0].due == cyc);
      chk("done", done, exp_done);
      if (done && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("hi_result", hi, mon_e.hi);
        chk("lo_result", lo, mon_e.lo);
        mhi = mon_e.hi; mlo = mon_e.lo;
      end else if (exp_done) begin
        mon_e = sb.pop_front();
        mhi = mon_e.hi; mlo = mon_e.lo;
      end
      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
      chk("hi_hold", hi, mhi);
      chk("lo_hold", lo, mlo);
    end
  end

  task automatic alu_chk(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUctr = c; src_1 = a; src_2 = b;
    #1;
    chk("alu", result, alu_ref(c, a, b));
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int g;
    g = 0;
    @(posedge clk); #1;
    while (cyc + 1 < free_edge && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    md_op = op; src_1 = a; src_2 = b; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    src_1 = $urandom(); src_2 = $urandom(); md_op = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int g, t64;
    bit got;
    rst = 1'b1; rst64 = 1'b1; md_start = 1'b0; md_op = '0; src_1 = '0; src_2 = '0; ALUctr = '0;
    start64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; alu64 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst64 = 1'b0; mon_en = 1'b1;

    alu_chk(4'b0111, 32'hFFFF_FFFF, 32'h1);
    alu_chk(4'b0011, 32'hFFFF_FFFF, 32'h1);
    alu_chk(4'b1010, 32'h4, 32'h8000_0000);
    alu_chk(4'b0010, 32'hFFFF_FFFF, 32'h2);
    alu_chk(4'b0110, 32'h0, 32'h1);
    alu_chk(4'b0100, 32'h0, 32'hABCD_1234);
    alu_chk(4'b1000, 32'h1F, 32'h3);
    alu_chk(4'b1111, 32'h5, 32'h6);

    // 64-bit instance: zero-extended LUI, full-width shifts, max multu
    @(posedge clk); #1;
    alu64 = 4'b0100; b64 = 64'hFFFF_FFFF_FFFF_1234; #1;
    chk("alu64_lui", res64, 64'h0000_0000_1234_0000);
    alu64 = 4'b1010; a64 = 64'd4; b64 = 64'h8000_0000_0000_0000; #1;
    chk("alu64_sra", res64, 64'hF800_0000_0000_0000);
    alu64 = 4'b1000; a64 = 64'd63; b64 = 64'd1; #1;
    chk("alu64_sll63", res64, 64'h8000_0000_0000_0000);
    @(posedge clk); #1;
    op64 = 2'b01; a64 = '1; b64 = '1; start64 = 1'b1; t64 = cyc + 1;
    @(posedge clk); #1;
    start64 = 1'b0; a64 = '0; b64 = '0;
    got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      @(negedge clk);
      if (done64) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done64_timeout cyc=%0d actual=none required=done", cyc);
    end else begin
      chk("done64_latency", cyc - t64, 64'd66);
      chk("hi64", hi64, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("lo64", lo64, 64'h1);
      chk("busy64_idle", busy64, 0);
    end

    // Directed multiply/divide corners, issued back-to-back
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd7, 32'd0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);

    // Abort a multu with reset (start held high alongside), then restart
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1; md_start = 1'b1; src_1 = 32'd3; src_2 = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; md_start = 1'b0;
    issue(2'b01, 32'd1000, 32'd3000);

    // Random traffic: start mostly held high, operands and ALU ops churning
    for (int i = 0; i < 1400; i++) begin
      @(posedge clk); #1;
      md_start = ($urandom_range(0, 3) != 0);
      md_op    = 2'($urandom_range(0, 3));
      src_1    = rnd_op();
      src_2    = rnd_op();
      ALUctr   = 4'($urandom_range(0, 15));
      #1;
      chk("alu_rand", result, alu_ref(ALUctr, src_1, src_2));
    end
    @(posedge clk); #1;
    md_start = 1'b0;

    g = 0;
    while ((sb.size() != 0 || cyc <= busy_to) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (g >= 100) begin
      failures++;
      $display("FAIL drain_timeout cyc=%0d actual=%0d pending required=0", cyc, sb.size());
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ALUctr  input  4  combinational operation select.
REQ-006 src_1  input  WIDTH  operand A; shift amount is src_1[SHW-1:0].
REQ-007 src_2  input  WIDTH  operand B.
REQ-008 result  output  WIDTH  combinational ALU result.
REQ-009 md_start  input  1  request a multiply/divide on src_1, src_2.
REQ-010 md_op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-011 busy  output  1  multiply/divide in progress.
REQ-012 done  output  1  one-cycle pulse: hi/lo just updated.
REQ-013 hi  output  WIDTH  product upper half / remainder.
REQ-014 lo  output  WIDTH  product lower half / quotient.

Function
REQ-015 result SHALL be: 0010 A+B; 0110 A-B; 0000 A&B; 0001 A|B; 0111 signed A<B ? 1:0; 0011 unsigned A<B ? 1:0; 0100 {B[15:0],16'b0} zero-extended to WIDTH; 1000 B<<shamt; 1001 B>>shamt logical; 1010 B>>>shamt arithmetic; 1100 ~(A|B); 1101 A^B; all other codes 0.
REQ-016 Add/sub SHALL wrap modulo 2^WIDTH, no overflow flag; result has no latch and no clock dependence.
REQ-017 A request SHALL be accepted at edge T when md_start=1 and the FSM is IDLE; src_1, src_2, md_op captured at T, later changes ignored.
REQ-018 md_start while busy=1 SHALL be ignored, not queued.
REQ-019 FSM states IDLE -> PREP (1 cycle: operand magnitudes, result sign) -> RUN (exactly WIDTH cycles, one iteration each) -> FIX (1 cycle: sign correction, hi/lo write) -> IDLE.
REQ-020 busy SHALL equal (state != IDLE): high cycles T+1..T+WIDTH+2.
REQ-021 hi/lo SHALL change and done SHALL be 1 in cycle T+WIDTH+3 only (T+35 for WIDTH=32); hi/lo hold otherwise.
REQ-022 md_start in the done cycle SHALL be accepted (back-to-back issue, no bubble).
REQ-023 Multiply: unsigned shift-add on magnitudes; {hi,lo} = full 2*WIDTH product, two's-complement negated when signed and operand signs differ.
REQ-024 Divide: restoring, on magnitudes; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-025 Divide by zero: lo = all ones, hi = dividend (raw src_1), full latency, done pulses normally.
REQ-026 Signed MIN / -1: lo = MIN, hi = 0, no exception.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter 0.
REQ-028 rst mid-operation SHALL abort; no hi/lo update and no done pulse for the aborted request.
REQ-029 rst SHALL take priority over a simultaneous md_start.

Structure
REQ-030 Package alu_pkg SHALL hold ALUctr encodings, md_op encodings, FSM state enum; shared with the pipeline decoder.
REQ-031 Iterative engine SHALL be one sub-module mdu_iter (PREP/RUN/FIX datapath, counter, FSM); alu_mdu holds the combinational ALU and instantiates it.
REQ-032 Iteration counter width SHALL be SHW+1.

Verification
REQ-033 WIDTH=32: ALUctr 0111, A=0xFFFFFFFF, B=1 -> result 1; ALUctr 0011 same operands -> result 0; ALUctr 1010, A=4, B=0x80000000 -> 0xF8000000.
REQ-034 mult A=-3 (0xFFFFFFFD), B=7 -> busy cycles T+1..T+34, done at T+35, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 div A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 md_start held high with operands changing every cycle during busy -> exactly one done per 34+1 cycles, each result from the operands at its own acceptance edge.
REQ-037 rst pulsed at T+10 of a multu -> busy=0, hi=lo=0 from T+11, no done; new start at T+12 completes normally at T+47.
REQ-038 WIDTH=64: multu 0xFFFFFFFFFFFFFFFF squared -> hi=0xFFFFFFFFFFFFFFFE, lo=1, done at T+67.
